// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, mid-bit
// sampling, a ready/acknowledge handshake and framing-error/overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10400
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       RDY,
  input  logic       ACK,
  output logic       BUSY,
  output logic       FRAMEERR,
  output logic       OVERRUN
);

  // Counter holds 0 .. CLKS_PER_BIT-1, so it never wraps inside a bit period.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Next-state logic: frame sequencing, sampling and the RDY handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = ACK ? 1'b0 : rdy_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Good byte: a coincident ACK consumes the old byte, so no overrun.
            data_d  = shift_q;
            rdy_d   = 1'b1;
            ovr_d   = rdy_q & ~ACK;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign DATA     = data_q;
  assign RDY      = rdy_q;
  assign BUSY     = busy_q;
  assign FRAMEERR = ferr_q;
  assign OVERRUN  = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: cycle-by-cycle comparison against a frame-timing
// model plus directed literal checks of the key scenarios.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int H     = CPB / 2;
  localparam int DEF_H = 10400 / 2;

  logic       CLK, RST, RX, ACK;
  logic [7:0] DATA;
  logic       RDY, BUSY, FRAMEERR, OVERRUN;
  logic       rx2;
  logic [7:0] data2;
  logic       rdy2, busy2, fe2, ov2;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .DATA(DATA), .RDY(RDY), .ACK(ACK),
    .BUSY(BUSY), .FRAMEERR(FRAMEERR), .OVERRUN(OVERRUN)
  );

  uart_rx u_def (
    .CLK(CLK), .RST(RST), .RX(rx2), .DATA(data2), .RDY(rdy2), .ACK(1'b0),
    .BUSY(busy2), .FRAMEERR(fe2), .OVERRUN(ov2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // A frame is timed from the edge where the synchronized line is first seen
  // low while idle: mid-start at +H, data bit i at +H+(i+1)*CPB, stop at +H+9*CPB.
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BREAK = 2;

  logic       s1, s2, s;
  int         m_mode, t0, cyc, rel;
  logic [7:0] bits;
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ov, good;

  initial cyc = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 = 1'b1; s2 = 1'b1; m_mode = M_IDLE; t0 = 0; bits = 8'h00;
      m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      s  = s2;
      s2 = s1;
      s1 = RX;
      m_fe = 1'b0; m_ov = 1'b0; good = 1'b0;
      if (m_mode == M_IDLE) begin
        if (!s) begin t0 = cyc; m_mode = M_FRAME; end
      end else if (m_mode == M_FRAME) begin
        rel = cyc - t0;
        if (rel == H) begin
          if (s) m_mode = M_IDLE;
        end else if (rel > H && rel < H + 9 * CPB) begin
          if ((rel - H) % CPB == 0) bits[(rel - H) / CPB - 1] = s;
        end else if (rel == H + 9 * CPB) begin
          if (s) begin good = 1'b1; m_mode = M_IDLE; end
          else begin m_fe = 1'b1; m_mode = M_BREAK; end
        end
      end else begin
        if (s) m_mode = M_IDLE;
      end
      if (good) begin
        m_ov   = m_rdy && !ACK;
        m_rdy  = 1'b1;
        m_data = bits;
      end else if (ACK) begin
        m_rdy = 1'b0;
      end
      cyc++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Start, 8 data bits LSB first, stop bit of stop_len cycles; RX is left at
  // the stop level so a low stop bit keeps the line in break.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cycles(CPB);
    end
    RX = stop;
    wait_cycles(stop_len);
  endtask

  task automatic ack_pulse();
    ACK = 1'b1;
    wait_cycles(1);
    ACK = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (FRAMEERR) fe_cnt++;
      if (OVERRUN)  ov_cnt++;
      if (!RST) begin
        check("model_DATA", DATA, m_data);
        check("model_RDY", RDY, m_rdy);
        check("model_BUSY", BUSY, m_mode != M_IDLE);
        check("model_FRAMEERR", FRAMEERR, m_fe);
        check("model_OVERRUN", OVERRUN, m_ov);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int  fe0, ov0, bcnt;
  bit  done;
  int  kind, stop_len;
  logic [7:0] rb;
  logic rstop;

  initial begin
    RX = 1'b1; rx2 = 1'b1; ACK = 1'b0; RST = 1'b1; done = 1'b0;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
      end
    join_none

    @(posedge CLK);
    wait_cycles(3);
    check("reset_DATA", DATA, 8'h00);
    check("reset_RDY", RDY, 1'b0);
    check("reset_BUSY", BUSY, 1'b0);
    check("reset_FRAMEERR", FRAMEERR, 1'b0);
    check("reset_OVERRUN", OVERRUN, 1'b0);
    RST = 1'b0;
    wait_cycles(2);

    // Default-parameter instance: a 3000-cycle low is a glitch caught at mid-start.
    rx2 = 1'b0; bcnt = 0;
    for (int i = 0; i < 5400; i++) begin
      wait_cycles(1);
      if (i == 2999) rx2 = 1'b1;
      if (busy2) bcnt++;
    end
    check("def_glitch_busy_cycles", bcnt, DEF_H);
    check("def_glitch_BUSY", busy2, 1'b0);
    check("def_glitch_RDY", rdy2, 1'b0);
    check("def_glitch_DATA", data2, 8'h00);

    // 4-cycle glitch on the CPB=16 instance.
    RX = 1'b0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      wait_cycles(1);
      if (i == 3) RX = 1'b1;
      if (BUSY) bcnt++;
    end
    check("glitch_busy_cycles", bcnt, H);
    check("glitch_BUSY", BUSY, 1'b0);
    check("glitch_RDY", RDY, 1'b0);
    check("glitch_DATA", DATA, 8'h00);

    // Good 0x55 frame: RDY rises on edge 155 after the RX falling edge.
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        wait_cycles(154);
        check("good55_RDY_before", RDY, 1'b0);
        wait_cycles(1);
        check("good55_RDY_after", RDY, 1'b1);
        check("good55_DATA", DATA, 8'h55);
      end
    join
    check("good55_no_FRAMEERR", fe_cnt - fe0, 0);
    check("good55_no_OVERRUN", ov_cnt - ov0, 0);

    // Framing error: 0xA5 with low stop, line held low, then a clean 0x3C.
    ack_pulse();
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, CPB);
    wait_cycles(40);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_BUSY_in_break", BUSY, 1'b1);
    check("ferr_RDY", RDY, 1'b0);
    check("ferr_DATA_kept", DATA, 8'h55);
    RX = 1'b1;
    wait_cycles(5);
    check("ferr_BUSY_released", BUSY, 1'b0);
    send_frame(8'h3C, 1'b1, CPB);
    wait_cycles(4);
    check("after_ferr_DATA", DATA, 8'h3C);
    check("after_ferr_RDY", RDY, 1'b1);

    // Overrun: 0x11 (short stop, start seen right after the stop sample) then 0x22.
    ack_pulse();
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, CPB);
    wait_cycles(3);
    check("overrun_pulses", ov_cnt - ov0, 1);
    check("overrun_DATA", DATA, 8'h22);
    check("overrun_RDY", RDY, 1'b1);

    // Same pair with ACK on the 0x22 completion edge: no overrun.
    ack_pulse();
    ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
      end
      begin
        wait_cycles(160 + 154);
        ACK = 1'b1;
        wait_cycles(1);
        ACK = 1'b0;
      end
    join
    wait_cycles(3);
    check("ack_coincident_no_overrun", ov_cnt - ov0, 0);
    check("ack_coincident_RDY", RDY, 1'b1);
    check("ack_coincident_DATA", DATA, 8'h22);

    // Reset during data bit 3 of 0xFF, then a clean 0x81.
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1, CPB);
      begin
        wait_cycles(4 * CPB + H);
        RST = 1'b1;
        #1;
        check("midreset_DATA", DATA, 8'h00);
        check("midreset_RDY", RDY, 1'b0);
        check("midreset_BUSY", BUSY, 1'b0);
        check("midreset_FRAMEERR", FRAMEERR, 1'b0);
        check("midreset_OVERRUN", OVERRUN, 1'b0);
        wait_cycles(3);
        RST = 1'b0;
      end
    join
    wait_cycles(3);
    check("midreset_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("midreset_RDY_after", RDY, 1'b0);
    send_frame(8'h81, 1'b1, CPB);
    wait_cycles(4);
    check("after_reset_DATA", DATA, 8'h81);
    check("after_reset_RDY", RDY, 1'b1);

    // Randomized traffic with random ACKs, glitches, bad stops, short stops.
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          kind = $urandom_range(0, 7);
          if (kind == 0) begin
            RX = 1'b0;
            wait_cycles($urandom_range(1, 6));
            RX = 1'b1;
            wait_cycles(12);
          end else begin
            rb       = 8'($urandom);
            rstop    = (kind != 1);
            stop_len = (kind == 2) ? $urandom_range(10, 16) : CPB;
            send_frame(rb, rstop, stop_len);
            if (!rstop) begin
              wait_cycles($urandom_range(0, 30));
              RX = 1'b1;
              wait_cycles(4);
            end
            if (kind != 2) wait_cycles($urandom_range(0, 12));
          end
        end
        RX = 1'b1;
        wait_cycles(20);
        done = 1'b1;
      end
      begin
        while (!done) begin
          ACK = ($urandom_range(0, 7) == 0);
          wait_cycles(1);
        end
        ACK = 1'b0;
      end
    join

    wait_cycles(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10400, CLK cycles per serial bit period; legal values are 4 and above.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port RX  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port DATA  output  8  most recently received good byte.
REQ-006 SHALL have port RDY  output  1  high while DATA holds an unacknowledged byte.
REQ-007 SHALL have port ACK  input  1  consumer acknowledge; clears RDY.
REQ-008 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port FRAMEERR  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port OVERRUN  output  1  one-cycle pulse when a good byte completes while RDY is already high.

Function
REQ-011 SHALL pass RX through a two-flop synchronizer (rx_s); all decisions use rx_s only, giving 2 cycles of input latency.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and BREAK, plus a bit-period counter and a 3-bit bit index.
REQ-013 In IDLE, when rx_s=0, SHALL enter START with the counter cleared.
REQ-014 In START, when counter = CLKS_PER_BIT/2 - 1 (integer division), SHALL enter DATA with counter and bit index cleared if rx_s=0; otherwise SHALL return to IDLE, treating the event as a glitch with no outputs changed.
REQ-015 In DATA, when counter = CLKS_PER_BIT - 1, SHALL shift rx_s into the shift register MSB and clear the counter; DATA bit 0 is the first received bit.
REQ-016 After the 8th data sample (bit index 7), SHALL enter STOP.
REQ-017 In STOP, when counter = CLKS_PER_BIT - 1 and rx_s=1, SHALL load DATA from the shift register, set RDY, and enter IDLE, all on the same edge.
REQ-018 In STOP, when counter = CLKS_PER_BIT - 1 and rx_s=0, SHALL pulse FRAMEERR, leave DATA and RDY unchanged, and enter BREAK.
REQ-019 In BREAK, SHALL remain until rx_s=1, then enter IDLE; no start detection occurs in BREAK.
REQ-020 ACK=1 SHALL clear RDY on the next edge; ACK while RDY=0 SHALL have no effect.
REQ-021 If a good byte completes while RDY=1 and ACK=0, SHALL overwrite DATA, keep RDY=1, and pulse OVERRUN.
REQ-022 If a good byte completes on the same edge that ACK=1, SHALL set RDY=1 with the new DATA and SHALL NOT pulse OVERRUN.
REQ-023 DATA SHALL change only on good-byte completion.
REQ-024 SHALL detect a start bit on the cycle after a good stop sample when rx_s is already low (back-to-back frames).
REQ-025 The counter SHALL be wide enough for CLKS_PER_BIT - 1 and SHALL never wrap inside a bit period.

Reset
REQ-026 While RST=1, SHALL asynchronously force: state=IDLE, counter=0, bit index=0, shift register=0, DATA=8'h00, RDY=0, BUSY=0, FRAMEERR=0, OVERRUN=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no RDY, FRAMEERR or OVERRUN; after release, reception SHALL resume at the next falling edge of rx_s.

Verification
REQ-028 Good frame: CLKS_PER_BIT=16, send 0x55 -> RDY rises and DATA=8'h55 within 1 cycle after the mid-stop sample; FRAMEERR=0 and OVERRUN=0 throughout.
REQ-029 Glitch: RX low for 4 cycles, then high -> state returns to IDLE, BUSY drops, RDY remains 0, DATA unchanged.
REQ-030 Framing error: send 0xA5 with stop bit 0, then hold RX low for 40 cycles -> one FRAMEERR pulse, RDY=0, BUSY stays high until RX returns high, then a following 0x3C frame is received correctly.
REQ-031 Overrun: send 0x11 then 0x22 back-to-back without ACK -> one OVERRUN pulse, DATA=8'h22, RDY=1; repeat with ACK coincident with the 0x22 completion edge -> no OVERRUN, RDY=1.
REQ-032 Reset mid-frame: assert RST during data bit 3 of 0xFF -> all outputs at reset values immediately; after release, a clean 0x81 frame gives DATA=8'h81 and RDY=1.
REQ-033 Default parameter: CLKS_PER_BIT=10400, send 0x40 -> DATA=8'h40, with the mid-stop sample at 9.5 × 10400 cycles (± 2 cycles of synchronizer latency) after the RX falling edge.
